// File: rtl/normalize_72.sv
// Iterative normalizer for 72-bit kv10 fractions: up to 8 bits of left shift per SHIFT cycle.
// Build option NORM_FAST_ZERO_EN: an all-zero input skips SHIFT and goes straight to DONE.
module normalize_72 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:71] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:71] out_word,
  output logic [0:8]  out_count,
  output logic        out_zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [0:71] word_q, word_d;
  logic [6:0]  count_q, count_d;
  logic        zero_q, zero_d;
  logic [3:0]  lead_k;
  logic        run;

  // Length of the run of sign copies in bits 1..8 (0..8).
  always_comb begin
    lead_k = 4'd0;
    run    = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (run && (word_q[i] == word_q[0])) lead_k = lead_k + 4'd1;
      else                                 run    = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
`ifdef NORM_FAST_ZERO_EN
          if (in_word == '0) begin
            state_d = DONE;
            word_d  = '0;
            count_d = 7'd0;
            zero_d  = 1'b1;
          end else begin
            state_d = SHIFT;
            word_d  = in_word;
            count_d = 7'd0;
            zero_d  = 1'b0;
          end
`else
          state_d = SHIFT;
          word_d  = in_word;
          count_d = 7'd0;
          zero_d  = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (lead_k != 4'd8) begin
          word_d  = word_q << lead_k;
          count_d = count_q + {3'b000, lead_k};
          state_d = DONE;
        end else if (count_q < 7'd64) begin
          word_d  = word_q << 8;
          count_d = count_q + 7'd8;
        end else begin
          // Eight full runs of sign copies plus zero fill: only an all-zero word gets here.
          word_d  = '0;
          count_d = 7'd0;
          zero_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      count_q <= 7'd0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_word  = word_q;
  assign out_count = {2'b00, count_q};
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_normalize_72.sv
// Bench for normalize_72: directed table, backpressure/reset sequences, randomized words vs. a search-based model.
module tb_normalize_72;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [0:71] in_word, out_word;
  logic [0:8]  out_count;
  int          n_vec = 0;
  int          n_err = 0;

`ifdef NORM_FAST_ZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 10;
`endif

  normalize_72 dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_count(out_count), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:71] word;
    logic [0:71] exp_word;
    int          exp_count;
    bit          exp_zero;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %o expected %o", name, act, exp);
    end
  endtask

  // Smallest left shift after which bit 0 and bit 1 differ; zero for the all-zero word.
  function automatic int ref_count(input logic [0:71] w);
    logic [0:71] t;
    for (int c = 0; c < 72; c++) begin
      t = w << c;
      if (t[0] != t[1]) return c;
    end
    return 0;
  endfunction

  function automatic int ref_lat(input logic [0:71] w);
    if (w == '0) return ZERO_LAT;
    return ref_count(w) / 8 + 2;
  endfunction

  task automatic run_word(input logic [0:71] w, input int stall,
                          output logic [0:71] ow, output int oc, output bit oz, output int lat);
    int guard;
    bit held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", 72'(in_ready), 72'(1));
    in_word  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_word  = 72'({$urandom, $urandom, $urandom});
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    ow = out_word;
    oc = int'(out_count);
    oz = out_zero;
    held = 1'b1;
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_word !== ow || out_count !== 9'(oc) ||
          out_zero !== oz || in_ready !== 1'b0) held = 1'b0;
    end
    in_valid = 1'b0;
    if (stall > 0) check("hold_under_backpressure", 72'(held), 72'(1));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid_ready", 72'({out_valid, in_ready}), 72'(2'b01));
    check("outputs_kept_in_idle", out_word, ow);
  endtask

  task automatic check_result(input string tag, input logic [0:71] w, input logic [0:71] ow,
                              input int oc, input bit oz, input int lat);
    logic [0:71] ew;
    int          ec;
    ec = ref_count(w);
    ew = (w == '0) ? '0 : (w << ec);
    check({tag, "_word"},  ow, ew);
    check({tag, "_count"}, 72'(oc), 72'(ec));
    check({tag, "_zero"},  72'(oz), 72'(w == '0));
    check({tag, "_lat"},   72'(lat), 72'(ref_lat(w)));
    if (!oz) begin
      check({tag, "_normform"}, 72'(ow[0] ^ ow[1]), 72'(1));
      check({tag, "_unshift"}, $signed(ow) >>> oc, w);
    end
  endtask

  initial begin
    vec_t        tbl [7];
    logic [0:71] ow, w;
    int          oc, lat, sh;
    bit          oz;

    tbl[0] = '{72'o000000000000_000000000001, 72'o200000000000_000000000000, 70, 1'b0, 10};
    tbl[1] = '{72'o377777777777_777777777777, 72'o377777777777_777777777777, 0, 1'b0, 2};
    tbl[2] = '{72'o777777777777_777777777777, 72'o400000000000_000000000000, 71, 1'b0, 10};
    tbl[3] = '{72'o000000000000_000000000000, 72'o000000000000_000000000000, 0, 1'b1, ZERO_LAT};
    tbl[4] = '{72'o040000000000_000000000000, 72'o200000000000_000000000000, 2, 1'b0, 2};
    tbl[5] = '{72'o777400000000_000000000000, 72'o400000000000_000000000000, 9, 1'b0, 3};
    tbl[6] = '{72'o700000000000_000000000000, 72'o400000000000_000000000000, 2, 1'b0, 2};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
    #12;
    check("reset_out_valid", 72'(out_valid), 72'(0));
    check("reset_out_word",  out_word, 72'(0));
    check("reset_out_count", 72'(out_count), 72'(0));
    check("reset_out_zero",  72'(out_zero), 72'(0));
    check("reset_in_ready",  72'(in_ready), 72'(1));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run_word(tbl[i].word, 0, ow, oc, oz, lat);
      check($sformatf("tbl%0d_word", i),  ow, tbl[i].exp_word);
      check($sformatf("tbl%0d_count", i), 72'(oc), 72'(tbl[i].exp_count));
      check($sformatf("tbl%0d_zero", i),  72'(oz), 72'(tbl[i].exp_zero));
      check($sformatf("tbl%0d_lat", i),   72'(lat), 72'(tbl[i].exp_lat));
    end

    w = 72'o000000000000_000000001000;
    run_word(w, 5, ow, oc, oz, lat);
    check_result("stall5", w, ow, oc, oz, lat);

    // Reset while SHIFT is iterating on a long input.
    while (!in_ready) begin @(posedge clk); #1; end
    in_word  = 72'o000000000000_000000000001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", 72'(out_valid), 72'(0));
    check("midreset_out_word",  out_word, 72'(0));
    check("midreset_out_count", 72'(out_count), 72'(0));
    check("midreset_out_zero",  72'(out_zero), 72'(0));
    check("midreset_in_ready",  72'(in_ready), 72'(1));
    @(posedge clk); #1;
    reset_n = 1'b1;
    w = 72'o000123456701_234567012345;
    run_word(w, 1, ow, oc, oz, lat);
    check_result("after_reset", w, ow, oc, oz, lat);

    for (int n = 0; n < 3000; n++) begin
      w  = 72'({$urandom, $urandom, $urandom});
      sh = int'($urandom_range(0, 71));
      w  = $signed(w) >>> sh;
      if ($urandom_range(0, 49) == 0) w = '0;
      run_word(w, int'($urandom_range(0, 3)), ow, oc, oz, lat);
      check_result($sformatf("rand%0d", n), w, ow, oc, oz, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
